// File: rtl/uart_rx_capture.sv
// 8N1 console receiver: 2-flop sync, mid-bit sampling, FWFT byte FIFO with valid/ready output.
// Byte visible 2 cycles after stop-bit sample; full FIFO drops new bytes (sticky io_overflow) unless popped same cycle.
module uart_rx_capture #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          io_clock,
    input  logic                          io_reset,
    input  logic                          io_rxd,
    input  logic                          io_clear,
    output logic                          io_data_valid,
    input  logic                          io_data_ready,
    output logic [DATA_BITS-1:0]          io_data_payload,
    output logic [$clog2(FIFO_DEPTH):0]   io_count,
    output logic                          io_busy,
    output logic                          io_frameError,
    output logic                          io_overflow
);
    localparam int DIVISOR = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W   = $clog2(DIVISOR);
    localparam int IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 busy_q, push_q, frame_err_q;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 ovf_q;
    logic                 full, pop, do_push;

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= io_rxd;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Counter restarts at zero on each state entry; HALF_LAST/FULL_LAST mark the sample cycle.
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            push_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign full    = (count_q == CNT_FULL);
    assign pop     = io_data_valid && io_data_ready;
    assign do_push = push_q && (!full || pop);

    // shift_q is stable during the push cycle, so it feeds the FIFO directly.
    always_ff @(posedge io_clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (!do_push && pop) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
            if (push_q && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (io_clear) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign io_data_valid   = (count_q != '0);
    assign io_data_payload = io_data_valid ? mem_q[rd_ptr_q] : '0;
    assign io_count        = count_q;
    assign io_busy         = busy_q;
    assign io_frameError   = frame_err_q;
    assign io_overflow     = ovf_q;
endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture at 16 clocks/bit with a 4-entry FIFO.
// Expected bytes come from the sent-byte list; pops are logged just before each rising edge.
module tb_uart_rx_capture;
    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst, rxd, clr, rdy;
    logic       vld, busy, fe, ovf;
    logic [7:0] pay;
    logic [2:0] cnt;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] got_q[$];
    int         fe_cnt = 0, fe_run = 0, fe_maxw = 0;
    bit         rand_rdy = 1'b0;

    always #5 clk = ~clk;

    uart_rx_capture #(
        .CLK_FREQ_HZ(1600000),
        .BAUD       (100000),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .io_clock       (clk),
        .io_reset       (rst),
        .io_rxd         (rxd),
        .io_clear       (clr),
        .io_data_valid  (vld),
        .io_data_ready  (rdy),
        .io_data_payload(pay),
        .io_count       (cnt),
        .io_busy        (busy),
        .io_frameError  (fe),
        .io_overflow    (ovf)
    );

    always @(negedge clk) begin
        #4;
        if (vld === 1'b1 && rdy === 1'b1) got_q.push_back(pay);
    end

    always @(negedge clk) begin
        if (fe === 1'b1) begin
            fe_run++;
            if (fe_run == 1) fe_cnt++;
            if (fe_run > fe_maxw) fe_maxw = fe_run;
        end else begin
            fe_run = 0;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stop_bit;
        tick(DIV);
    endtask

    task test_reset;
        rst = 1'b1; rxd = 1'b1; clr = 1'b0; rdy = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (vld !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%0b exp=0", vld); end
        checks++; if (pay !== 8'h00) begin failures++; $display("FAIL reset_payload got=%h exp=00", pay); end
        checks++; if (cnt !== 3'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (fe !== 1'b0)   begin failures++; $display("FAIL reset_frameError got=%0b exp=0", fe); end
        checks++; if (ovf !== 1'b0)  begin failures++; $display("FAIL reset_overflow got=%0b exp=0", ovf); end
    endtask

    task test_single;
        int         fe0;
        logic [7:0] g;
        got_q.delete();
        fe0 = fe_cnt;
        rdy = 1'b1;
        tick(2);
        send_byte(8'hA5, 1'b1);
        tick(10);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", got_q.size()); end
        checks++; if (g !== 8'hA5) begin failures++; $display("FAIL single_payload got=%h exp=a5", g); end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL single_frameError got=%0d exp=0", fe_cnt - fe0); end
        checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", cnt); end
    endtask

    task test_glitch;
        int n;
        int fe0;
        got_q.delete();
        fe0 = fe_cnt;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%0b exp=1", busy); end
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n > 10) begin failures++; $display("FAIL glitch_busy_fall got=%0d cycles exp<=10", n); end
        tick(20);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_no_push got=%0d exp=0", got_q.size()); end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL glitch_frameError got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task test_framing;
        int fe0;
        bit dropped;
        got_q.delete();
        fe0 = fe_cnt;
        fe_maxw = 0;
        rdy = 1'b1;
        send_byte(8'h3C, 1'b0);
        dropped = 1'b0;
        repeat (40) begin
            tick(1);
            if (busy !== 1'b1) dropped = 1'b1;
        end
        checks++; if (dropped) begin failures++; $display("FAIL framing_hold_busy got=0 exp=1"); end
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL framing_pulses got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (fe_maxw != 1) begin failures++; $display("FAIL framing_width got=%0d exp=1", fe_maxw); end
        checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL framing_count got=%0d exp=0", cnt); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL framing_no_push got=%0d exp=0", got_q.size()); end
        rxd = 1'b1;
        tick(6);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL framing_release_busy got=%0b exp=0", busy); end
    endtask

    task test_overflow;
        logic [7:0] g;
        got_q.delete();
        rdy = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            send_byte(8'(v), 1'b1);
            tick(4);
        end
        @(negedge clk);
        checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", cnt); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", ovf); end
        checks++; if (pay !== 8'h01) begin failures++; $display("FAIL ovf_head got=%h exp=01", pay); end
        tick(1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", ovf); end
        rdy = 1'b1;
        tick(8);
        rdy = 1'b0;
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ovf_pops got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== 8'(i + 1)) begin failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, g, 8'(i + 1)); end
        end
    endtask

    task test_push_pop_full;
        logic [7:0] exp_b[5];
        logic [7:0] g;
        int         k;
        bit         timeout;
        exp_b = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h06};
        got_q.delete();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(exp_b[i], 1'b1);
            tick(4);
        end
        checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL full_fill_count got=%0d exp=4", cnt); end
        timeout = 1'b0;
        fork
            send_byte(8'h06, 1'b1);
            begin
                k = 0;
                while (busy !== 1'b1 && k < 400) begin @(negedge clk); k++; end
                if (k >= 400) timeout = 1'b1;
                k = 0;
                while (busy !== 1'b0 && k < 400) begin @(negedge clk); k++; end
                if (k >= 400) timeout = 1'b1;
                #2;
                rdy = 1'b1;
                @(posedge clk);
                #1;
                rdy = 1'b0;
            end
        join
        checks++; if (timeout) begin failures++; $display("FAIL full_busy_wait got=timeout exp=busy edges"); end
        tick(2);
        @(negedge clk);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL full_pushpop_ovf got=%0b exp=0", ovf); end
        checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL full_pushpop_count got=%0d exp=4", cnt); end
        rdy = 1'b1;
        tick(8);
        rdy = 1'b0;
        checks++; if (got_q.size() != 5) begin failures++; $display("FAIL full_pops got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin failures++; $display("FAIL full_order[%0d] got=%h exp=%h", i, g, exp_b[i]); end
        end
    endtask

    task test_random;
        logic [7:0] exp_q[$];
        logic [7:0] b, g;
        int         fe0;
        got_q.delete();
        fe0 = fe_cnt;
        rand_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b, 1'b1);
            tick($urandom_range(1, 20));
        end
        rand_rdy = 1'b0;
        tick(2);
        rdy = 1'b1;
        tick(10);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_pops got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL random_byte[%0d] got=%h exp=%h", i, g, exp_q[i]); end
        end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL random_ovf got=%0b exp=0", ovf); end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL random_frameError got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task test_reset_mid;
        logic [7:0] g;
        got_q.delete();
        rdy = 1'b0;
        send_byte(8'h77, 1'b1);
        tick(3);
        checks++; if (cnt !== 3'd1) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=1", cnt); end
        fork
            send_byte(8'hFF, 1'b1);
            begin
                tick(DIV + 3 * DIV + DIV / 2);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                @(negedge clk);
                checks++; if (vld !== 1'b0)  begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", vld); end
                checks++; if (pay !== 8'h00) begin failures++; $display("FAIL rstmid_payload got=%h exp=00", pay); end
                checks++; if (cnt !== 3'd0)  begin failures++; $display("FAIL rstmid_count got=%0d exp=0", cnt); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
                checks++; if (fe !== 1'b0)   begin failures++; $display("FAIL rstmid_frameError got=%0b exp=0", fe); end
                checks++; if (ovf !== 1'b0)  begin failures++; $display("FAIL rstmid_overflow got=%0b exp=0", ovf); end
            end
        join
        rdy = 1'b1;
        tick(5);
        send_byte(8'h55, 1'b1);
        tick(10);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL rstmid_pops got=%0d exp=1", got_q.size()); end
        checks++; if (g !== 8'h55) begin failures++; $display("FAIL rstmid_after got=%h exp=55", g); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_glitch;
        test_framing;
        test_overflow;
        test_push_pop_full;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
